// File: rtl/hazard_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : hazard_pkg
//  Description : Shared types, constants and helpers for the OTTER hazard
//                scoreboard (entry record, bubble constant, select width).
//  Revision    : 1.0 - initial release
// ============================================================================
package hazard_pkg;

  // Widest register address an entry can hold; narrower addresses are
  // zero-extended into the dest field.
  localparam int SB_DEST_W = 5;

  typedef struct packed {
    logic                 valid;
    logic                 we;
    logic                 is_load;
    logic [SB_DEST_W-1:0] dest;
  } sb_entry_t;

  // An empty pipeline slot: nothing in flight, matches no reader.
  localparam sb_entry_t SB_BUBBLE = '{valid: 1'b0, we: 1'b0, is_load: 1'b0, dest: '0};

  // Bits needed to encode 0 (register file) plus stages 1..n.
  function automatic int sel_width(input int n);
    int w;
    w = 1;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < (n + 1)) w = i + 1;
    end
    return w;
  endfunction

endpackage
`default_nettype wire

// File: rtl/hazard_scoreboard_fwd_port_select.sv
`default_nettype none
// ============================================================================
//  Module      : fwd_port_select
//  Description : Per-read-port forwarding source selection. Picks the
//                youngest in-flight writer of the read register and flags a
//                load whose data is not yet forwardable.
//  Revision    : 1.0 - initial release
// ============================================================================
module fwd_port_select
  import hazard_pkg::*;
#(
  parameter int NUM_STAGES       = 3,
  parameter int LOAD_READY_STAGE = 2,
  parameter int SEL_W            = sel_width(NUM_STAGES)
) (
  input  logic                             read_use_i,
  input  logic [SB_DEST_W-1:0]             read_reg_i,
  input  sb_entry_t [NUM_STAGES-1:0]       entries_i,
  output logic [SEL_W-1:0]                 sel_o,
  output logic                             hazard_o
);

  // Scan from youngest (stage 1) to oldest; the first writer hit wins.
  always_comb begin
    logic found;
    found    = 1'b0;
    sel_o    = '0;
    hazard_o = 1'b0;
    if (read_use_i && (read_reg_i != '0)) begin
      for (int k = 0; k < NUM_STAGES; k++) begin
        if (!found && entries_i[k].valid && entries_i[k].we &&
            (entries_i[k].dest != '0) && (entries_i[k].dest == read_reg_i)) begin
          found    = 1'b1;
          sel_o    = SEL_W'(k + 1);
          hazard_o = entries_i[k].is_load && ((k + 1) < LOAD_READY_STAGE);
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/hazard_scoreboard.sv
`default_nettype none
// ============================================================================
//  Module      : hazard_scoreboard
//  Description : Forwarding and load-use hazard unit for the pipelined OTTER
//                core. Shift-register scoreboard of in-flight writers (entry 1
//                = EX ... entry NUM_STAGES = WB) with per-port forward select.
//                Optional macro HAZ_PERF_EN adds saturating stall/forward
//                event counters.
//  Revision    : 1.0 - initial release
// ============================================================================
module hazard_scoreboard
  import hazard_pkg::*;
#(
  parameter int NUM_STAGES       = 3,
  parameter int NUM_READ         = 2,
  parameter int REG_ADDR_W       = 5,
  parameter int LOAD_READY_STAGE = 2,
  parameter int SEL_W            = sel_width(NUM_STAGES)
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  input  logic                           hold_i,
  input  logic                           flush_i,
  input  logic                           issue_valid_i,
  input  logic                           issue_we_i,
  input  logic                           issue_is_load_i,
  input  logic [REG_ADDR_W-1:0]          issue_dest_i,
  input  logic [NUM_READ-1:0]            read_use_i,
  input  logic [NUM_READ*REG_ADDR_W-1:0] read_reg_i,
  output logic [NUM_READ*SEL_W-1:0]      fwd_sel_o,
`ifdef HAZ_PERF_EN
  output logic [31:0]                    stall_cnt_o,
  output logic [31:0]                    fwd_cnt_o,
`endif
  output logic                           stall_o
);

  sb_entry_t [NUM_STAGES-1:0] entries_q;
  sb_entry_t [NUM_STAGES-1:0] entries_d;
  sb_entry_t                  issue_entry;
  logic [NUM_READ-1:0]        port_hazard;
  logic                       stall;

  generate
    for (genvar p = 0; p < NUM_READ; p++) begin : g_port
      fwd_port_select #(
        .NUM_STAGES       (NUM_STAGES),
        .LOAD_READY_STAGE (LOAD_READY_STAGE),
        .SEL_W            (SEL_W)
      ) u_sel (
        .read_use_i (read_use_i[p]),
        .read_reg_i (SB_DEST_W'(read_reg_i[p*REG_ADDR_W +: REG_ADDR_W])),
        .entries_i  (entries_q),
        .sel_o      (fwd_sel_o[p*SEL_W +: SEL_W]),
        .hazard_o   (port_hazard[p])
      );
    end
  endgenerate

  assign stall   = |port_hazard;
  assign stall_o = stall;

  // Next scoreboard contents: shift toward WB and insert the decode
  // instruction, or a single bubble when stalled, flushed or idle.
  always_comb begin
    entries_d   = entries_q;
    issue_entry = SB_BUBBLE;
    if (issue_valid_i && !flush_i && !stall) begin
      issue_entry = '{valid: 1'b1, we: issue_we_i, is_load: issue_is_load_i,
                      dest: SB_DEST_W'(issue_dest_i)};
    end
    if (!hold_i) begin
      for (int k = NUM_STAGES - 1; k > 0; k--) begin
        entries_d[k] = entries_q[k-1];
      end
      entries_d[0] = issue_entry;
    end
  end

  // Scoreboard register; reset drops every in-flight writer.
  always_ff @(posedge clk_i) begin
    if (rst_i) entries_q <= {NUM_STAGES{SB_BUBBLE}};
    else       entries_q <= entries_d;
  end

`ifdef HAZ_PERF_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;
  logic [31:0] fwd_cnt_q, fwd_cnt_d;

  // Saturating event counts over cycles where the pipeline advances.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    fwd_cnt_d   = fwd_cnt_q;
    if (!hold_i) begin
      if (stall && !(&stall_cnt_q)) stall_cnt_d = stall_cnt_q + 32'd1;
      if (!stall && (|fwd_sel_o) && !(&fwd_cnt_q)) fwd_cnt_d = fwd_cnt_q + 32'd1;
    end
  end

  // Counter registers, cleared by reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      stall_cnt_q <= '0;
      fwd_cnt_q   <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      fwd_cnt_q   <= fwd_cnt_d;
    end
  end

  assign stall_cnt_o = stall_cnt_q;
  assign fwd_cnt_o   = fwd_cnt_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_hazard_scoreboard.sv
`default_nettype none
// ============================================================================
//  Module      : tb_hazard_scoreboard
//  Description : Self-checking bench for hazard_scoreboard (3 stages, 2 read
//                ports, load ready at stage 2). Directed scenarios plus a
//                random run against a timestamp-based reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_hazard_scoreboard;

  localparam int NS  = 3;
  localparam int LRS = 2;
  localparam int HSZ = 8192;

  logic       clk;
  logic       rst, hold, flush, iv, iwe, ild;
  logic [4:0] idest;
  logic [1:0] ruse;
  logic [9:0] rreg;
  logic [3:0] fsel;
  logic       stall;
`ifdef HAZ_PERF_EN
  logic [31:0] stall_cnt, fwd_cnt;
`endif

  hazard_scoreboard #(
    .NUM_STAGES (NS),
    .NUM_READ (2),
    .REG_ADDR_W (5),
    .LOAD_READY_STAGE (LRS)
  ) dut (
    .clk_i (clk),
    .rst_i (rst),
    .hold_i (hold),
    .flush_i (flush),
    .issue_valid_i (iv),
    .issue_we_i (iwe),
    .issue_is_load_i (ild),
    .issue_dest_i (idest),
    .read_use_i (ruse),
    .read_reg_i (rreg),
    .fwd_sel_o (fsel),
`ifdef HAZ_PERF_EN
    .stall_cnt_o (stall_cnt),
    .fwd_cnt_o (fwd_cnt),
`endif
    .stall_o (stall)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: every pipeline advance is numbered; the instruction
  // issued at advance n sits at stage (adv - n). Reset moves the floor.
  typedef struct { bit v; bit we; bit ld; int dest; } ent_t;
  ent_t hist [HSZ];
  int   adv  = 0;
  int   base = 0;
  int   m_scnt = 0;
  int   m_fcnt = 0;
  int   checks = 0;
  int   failures = 0;

  function automatic ent_t m_entry(input int k);
    ent_t e;
    e = '{v: 0, we: 0, ld: 0, dest: 0};
    if (adv - k >= base) e = hist[(adv - k) % HSZ];
    return e;
  endfunction

  function automatic int m_sel(input int p);
    int   r;
    ent_t e;
    r = int'(rreg[p*5 +: 5]);
    if (!ruse[p] || r == 0) return 0;
    for (int k = 1; k <= NS; k++) begin
      e = m_entry(k);
      if (e.v && e.we && e.dest != 0 && e.dest == r) return k;
    end
    return 0;
  endfunction

  function automatic bit m_stall();
    int s;
    for (int p = 0; p < 2; p++) begin
      s = m_sel(p);
      if (s > 0 && s < LRS && m_entry(s).ld) return 1'b1;
    end
    return 1'b0;
  endfunction

  task automatic model_update();
    bit st;
    if (rst) begin
      base   = adv;
      m_scnt = 0;
      m_fcnt = 0;
    end else if (!hold) begin
      st = m_stall();
      if (st) m_scnt++;
      else if (m_sel(0) != 0 || m_sel(1) != 0) m_fcnt++;
      if (st || flush || !iv) hist[adv % HSZ] = '{v: 0, we: 0, ld: 0, dest: 0};
      else hist[adv % HSZ] = '{v: 1, we: iwe, ld: ild, dest: int'(idest)};
      adv++;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic drv(input bit v, input bit we, input bit ld, input int d,
                     input bit [1:0] u, input int r0, input int r1,
                     input bit h, input bit f, input bit r);
    iv = v; iwe = we; ild = ld; idest = 5'(d);
    ruse = u; rreg = {5'(r1), 5'(r0)};
    hold = h; flush = f; rst = r;
  endtask

  // One cycle: compare against the model (and hand constants when >= 0)
  // mid-cycle, then advance the clock and the model together.
  task automatic step(input string tag, input int e0, input int e1, input int est);
    @(negedge clk);
    chk({tag, ".sel0.model"}, 32'(fsel[1:0]), m_sel(0));
    chk({tag, ".sel1.model"}, 32'(fsel[3:2]), m_sel(1));
    chk({tag, ".stall.model"}, 32'(stall), int'(m_stall()));
    if (e0 >= 0) chk({tag, ".sel0"}, 32'(fsel[1:0]), e0);
    if (e1 >= 0) chk({tag, ".sel1"}, 32'(fsel[3:2]), e1);
    if (est >= 0) chk({tag, ".stall"}, 32'(stall), est);
`ifdef HAZ_PERF_EN
    chk({tag, ".stall_cnt"}, stall_cnt, m_scnt);
    chk({tag, ".fwd_cnt"}, fwd_cnt, m_fcnt);
`endif
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic drain();
    drv(0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0);
    repeat (NS) step("drain", -1, -1, -1);
  endtask

  initial begin
    drv(0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 1);
    repeat (2) @(posedge clk);
    #1;
    // Reset state
    drv(0, 0, 0, 0, 2'b11, 5, 5, 0, 0, 0);
    step("reset", 0, 0, 0);

    // add x5, then read it at stage 1, 2, 3 and after retirement
    drv(1, 1, 0, 5, 2'b00, 0, 0, 0, 0, 0);  step("add_issue", 0, 0, 0);
    drv(0, 0, 0, 0, 2'b01, 5, 0, 0, 0, 0);  step("fwd_s1", 1, 0, 0);
    step("fwd_s2", 2, 0, 0);
    step("fwd_s3", 3, 0, 0);
    step("fwd_ret", 0, 0, 0);
    drain();

    // lw x7 then dependent read on port 1: one stall cycle
    drv(1, 1, 1, 7, 2'b00, 0, 0, 0, 0, 0);  step("lw_issue", 0, 0, 0);
    drv(1, 1, 0, 10, 2'b10, 0, 7, 0, 0, 0); step("lu_stall", 0, 1, 1);
    step("lu_after", 0, 2, 0);
    drv(0, 0, 0, 0, 2'b11, 10, 7, 0, 0, 0); step("lu_s3", 1, 3, 0);
    drain();

    // x0 never forwards; WE=0 writer never forwards
    drv(1, 1, 0, 0, 2'b00, 0, 0, 0, 0, 0);  step("x0_issue", 0, 0, 0);
    drv(1, 0, 0, 3, 2'b11, 0, 0, 0, 0, 0);  step("x0_read", 0, 0, 0);
    drv(0, 0, 0, 0, 2'b01, 3, 0, 0, 0, 0);  step("nowe_read", 0, 0, 0);
    drain();

    // youngest wins; port 1 reaches stage 3
    drv(1, 1, 0, 4, 2'b00, 0, 0, 0, 0, 0);  step("y_x4", -1, -1, -1);
    drv(1, 1, 0, 3, 2'b00, 0, 0, 0, 0, 0);  step("y_add3", -1, -1, -1);
    drv(1, 1, 0, 3, 2'b00, 0, 0, 0, 0, 0);  step("y_sub3", -1, -1, -1);
    drv(0, 0, 0, 0, 2'b11, 3, 4, 0, 0, 0);  step("youngest", 1, 3, 0);
    drain();

    // lw x9 under HOLD: frozen, stall held, then one bubble
    drv(1, 1, 1, 9, 2'b00, 0, 0, 0, 0, 0);  step("h_lw", 0, 0, 0);
    drv(0, 0, 0, 0, 2'b01, 9, 0, 1, 0, 0);  step("hold1", 1, 0, 1);
    step("hold2", 1, 0, 1);
    drv(0, 0, 0, 0, 2'b01, 9, 0, 0, 0, 0);  step("hold_rel", 1, 0, 1);
    step("hold_fwd", 2, 0, 0);
    drain();

    // stall and flush together: single bubble
    drv(1, 1, 1, 8, 2'b00, 0, 0, 0, 0, 0);  step("sf_lw", 0, 0, 0);
    drv(1, 1, 0, 11, 2'b01, 8, 0, 0, 1, 0); step("sf_both", 1, 0, 1);
    drv(0, 0, 0, 0, 2'b11, 8, 11, 0, 0, 0); step("sf_after", 2, 0, 0);
    drain();

    // reset mid-operation discards lw x6
    drv(1, 1, 1, 6, 2'b00, 0, 0, 0, 0, 0);  step("r_lw", 0, 0, 0);
    drv(0, 0, 0, 0, 2'b01, 6, 0, 0, 0, 1);  step("r_assert", 1, 0, 1);
    drv(0, 0, 0, 0, 2'b01, 6, 0, 0, 0, 0);  step("r_after", 0, 0, 0);

    // randomized traffic on a small register set to force collisions
    for (int i = 0; i < 600; i++) begin
      drv(($urandom_range(0, 3) != 0), ($urandom_range(0, 3) != 0),
          ($urandom_range(0, 2) == 0), $urandom_range(0, 3),
          2'($urandom_range(0, 3)), $urandom_range(0, 3), $urandom_range(0, 3),
          ($urandom_range(0, 7) == 0), ($urandom_range(0, 7) == 0),
          ($urandom_range(0, 49) == 0));
      step("rand", -1, -1, -1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/hazard_scoreboard.md
Name: hazard_scoreboard

Overview:
- Parametrised forwarding and hazard unit for the pipelined OTTER core.
- Tracks in-flight register writers in a shift-register scoreboard of NUM_STAGES entries. Entry 1 is EX; entry NUM_STAGES is WB.
- For each of NUM_READ operand reads at decode, selects the youngest matching forwarding source.
- Raises a load-use stall when the matching writer is a load whose data is not yet available. On a stall it inserts a bubble.

Parameters:
- NUM_STAGES, 3, number of tracked in-flight stages after decode (EX..WB).
- NUM_READ, 2, number of source-register read ports at decode.
- REG_ADDR_W, 5, register address width.
- LOAD_READY_STAGE, 2, first stage index at which load data can be forwarded. Range 1..NUM_STAGES.
- SEL_W, $clog2(NUM_STAGES+1), derived width of one forward select.

Ports:
- CLK  in  1  clock.
- RST  in  1  synchronous, active-high reset.
- HOLD  in  1  external pipeline freeze (memory wait). Scoreboard holds.
- FLUSH  in  1  kill the decode instruction. A bubble is issued instead.
- ISSUE_VALID  in  1  decode instruction is valid.
- ISSUE_WE  in  1  decode instruction writes the register file.
- ISSUE_IS_LOAD  in  1  decode instruction is a load.
- ISSUE_DEST  in  REG_ADDR_W  decode destination register.
- READ_USE  in  NUM_READ  per-port: operand actually read.
- READ_REG  in  NUM_READ*REG_ADDR_W  packed source addresses, port 0 in LSBs.
- FWD_SEL  out  NUM_READ*SEL_W  packed per-port source: 0 = register file, k = stage k.
- STALL  out  1  load-use stall; hold IF/ID this cycle.

Behaviour:
- Entry state per stage: valid, we, is_load, dest. An entry "writes" iff valid && we && dest != 0.
- Reset: all entries invalid, which gives FWD_SEL = 0 and STALL = 0. The RST edge dominates HOLD, FLUSH and issue. Reset mid-operation discards all in-flight entries.
- FWD_SEL, combinational from current entries and READ_*:
  - Port p selects the smallest k whose entry writes and whose dest == READ_REG[p], and only when READ_USE[p] = 1.
  - If no entry matches, or READ_REG[p] = 0, FWD_SEL[p] = 0.
- STALL, combinational: asserted if any port p has its selected k with entry k is_load and k < LOAD_READY_STAGE. STALL is not masked by HOLD.
- Update rule, on each CLK edge when !RST:
  - If HOLD: all entries keep their values. FLUSH and issue are ignored.
  - Else, entry[k] <= entry[k-1] for k = 2..NUM_STAGES.
  - Entry[1] <= bubble (valid = 0) if STALL || FLUSH || !ISSUE_VALID.
  - Otherwise entry[1] <= {1, ISSUE_WE, ISSUE_IS_LOAD, ISSUE_DEST}.
  - The entry in stage NUM_STAGES retires (drops off the end).
- Latency: a writer issued at cycle t is matched as stage 1 at t+1 and as stage k at t+k (absent HOLD).
- Stall length: a load at stage 1 with LOAD_READY_STAGE = 2 gives 1 stall cycle. In general the stall lasts LOAD_READY_STAGE-1 cycles.
- Simultaneous STALL and FLUSH: a single bubble is inserted. No double effect.
- Multiple matches on one port: the youngest (lowest k) wins.
- Different ports are independent; each may select a different stage.

Optional Feature:
- Macro: HAZ_PERF_EN.
- When defined, adds two outputs: STALL_CNT (32 bit) and FWD_CNT (32 bit).
  - STALL_CNT increments on each non-HOLD cycle with STALL = 1.
  - FWD_CNT increments on each non-HOLD cycle where any FWD_SEL is nonzero and STALL = 0.
  - Both counters saturate at all-ones and clear on RST.
- When undefined, the ports and logic are absent. Functional behaviour is otherwise identical.

Decomposition:
- Shared package hazard_pkg holds:
  - typedef sb_entry_t {valid, we, is_load, dest};
  - constant SB_BUBBLE;
  - function sel_width(n).
- Natural sub-module: fwd_port_select. It takes one read address, READ_USE and the entry array, and outputs SEL_W select plus a load-hazard flag. It is instantiated NUM_READ times via generate.

Test Plan:
- Defaults for all scenarios: NUM_STAGES = 3, LOAD_READY_STAGE = 2.
- Issue add x5 (WE = 1), next cycle READ_REG0 = 5, READ_USE0 = 1 -> FWD_SEL[0] = 1, STALL = 0. One cycle later, with a nop in between -> FWD_SEL[0] = 2.
- Issue lw x7, next cycle READ_REG1 = 7 -> STALL = 1 for exactly 1 cycle and entry[1] becomes a bubble. The following cycle gives FWD_SEL[1] = 2, STALL = 0.
- Issue writer to x0, then read x0 on both ports -> FWD_SEL = 0, STALL = 0. Writer x3 with WE = 0 followed by a read of x3 -> FWD_SEL = 0.
- Issue add x3, then sub x3; read x3 -> FWD_SEL = 1 (youngest). Port 1 reading x4, written only at stage 3 -> FWD_SEL[1] = 3.
- Issue lw x9, assert HOLD for 2 cycles with a read of x9 -> entries frozen, STALL = 1 held. HOLD drops -> one bubble inserted, then FWD_SEL = 2.
- lw x6 at stage 1 with STALL high, assert RST for one cycle -> next cycle FWD_SEL = 0, STALL = 0. With HAZ_PERF_EN defined, STALL_CNT = 0 and FWD_CNT = 0.
